// File: rtl/load_hazard_tracker_pkg.sv
// Shared types and constants for the load-use hazard tracker.
// Optional perf counters are enabled with the HAZARD_PERF_EN macro (see top).
package hazard_pkg;

    localparam int REG_AW_DEF   = 5;
    localparam int CNT_W_DEF    = 4;
    localparam int MAX_LOAD_LAT = 8;

    localparam logic [REG_AW_DEF-1:0] X0 = '0;

    // One in-flight load: destination register and cycles left until forwardable.
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic [CNT_W_DEF-1:0]  cnt;
    } sb_entry_t;

    // True when a used, nonzero source register names the given destination.
    function automatic logic reg_hit(input logic use_r,
                                     input logic [REG_AW_DEF-1:0] rs,
                                     input logic [REG_AW_DEF-1:0] rd);
        return use_r && (rs != X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/load_hazard_tracker_if.sv
// Pipeline <-> hazard tracker signal bundle.
// master: the pipeline (drives ID/EX status), slave: the tracker (drives control).
interface load_hazard_tracker_if #(
    parameter int REG_AW = hazard_pkg::REG_AW_DEF
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_is_load;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              mem_stall;
    logic              ex_flush;

    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              tracker_full;
    logic [31:0]       perf_load_stall;
    logic [31:0]       perf_mem_stall;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_load,
               ex_valid, ex_rd, ex_mem_read, mem_stall, ex_flush,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               tracker_full, perf_load_stall, perf_mem_stall
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_load,
               ex_valid, ex_rd, ex_mem_read, mem_stall, ex_flush,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               tracker_full, perf_load_stall, perf_mem_stall
    );
endinterface

// File: rtl/load_hazard_tracker_sb_entry.sv
// Single scoreboard slot: holds one in-flight load, counts it down, and
// reports whether the instruction in ID depends on it.
module hazard_sb_entry
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  alloc,
    input  logic [REG_AW_DEF-1:0] alloc_rd,
    input  logic [CNT_W_DEF-1:0]  alloc_cnt,
    input  logic [REG_AW_DEF-1:0] rs1,
    input  logic [REG_AW_DEF-1:0] rs2,
    input  logic                  use_rs1,
    input  logic                  use_rs2,
    output logic                  valid,
    output logic                  hit
);

    sb_entry_t ent;

    // Allocate into an idle slot, otherwise count down; the slot frees on the
    // edge where cnt leaves 1. Nothing moves while the pipeline is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent <= '0;
        end else if (advance) begin
            if (alloc) begin
                ent.valid <= 1'b1;
                ent.rd    <= alloc_rd;
                ent.cnt   <= alloc_cnt;
            end else if (ent.valid) begin
                ent.valid <= (ent.cnt > CNT_W_DEF'(1));
                ent.cnt   <= ent.cnt - CNT_W_DEF'(1);
            end
        end
    end

    assign valid = ent.valid;
    assign hit   = ent.valid & (reg_hit(use_rs1, rs1, ent.rd) | reg_hit(use_rs2, rs2, ent.rd));

endmodule

// File: rtl/load_hazard_tracker.sv
// Load-use hazard controller for the 5-stage in-order pipeline. Stalls ID
// behind loads still in EX or still in flight in multi-cycle data memory,
// with mem_stall freeze and branch-flush priority.
// Optional macro HAZARD_PERF_EN adds the stall performance counters.
module load_hazard_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int LOAD_LAT  = 1,
    parameter int NUM_TRACK = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input logic clk,
    input logic rst_n,
    load_hazard_tracker_if.slave bus
);

    localparam bit              MULTI_CYC = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(LOAD_LAT - 1);

    if (REG_AW != REG_AW_DEF || CNT_W != CNT_W_DEF || NUM_TRACK < 1 ||
        LOAD_LAT < 1 || LOAD_LAT > MAX_LOAD_LAT) begin : g_bad_cfg
        $error("load_hazard_tracker: unsupported parameter combination");
    end

    logic                 ex_load;
    logic                 do_alloc;
    logic                 m_ex;
    logic                 m_sb;
    logic                 full;
    logic                 full_h;
    logic                 load_haz;
    logic                 slot_found;
    logic [NUM_TRACK-1:0] ent_valid;
    logic [NUM_TRACK-1:0] ent_hit;
    logic [NUM_TRACK-1:0] alloc_vec;

    assign ex_load  = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != X0);
    assign do_alloc = MULTI_CYC & ex_load;
    assign m_ex     = ex_load & (reg_hit(bus.id_use_rs1, bus.id_rs1, bus.ex_rd) |
                                 reg_hit(bus.id_use_rs2, bus.id_rs2, bus.ex_rd));
    assign m_sb     = |ent_hit;
    assign full     = &ent_valid;
    // A load in ID while every slot is busy would have nowhere to go once it
    // reaches EX, so hold it back.
    assign full_h   = full & bus.id_is_load & MULTI_CYC;
    assign load_haz = m_ex | m_sb | full_h;

    // Pick the lowest slot idle at cycle start; slots freeing this edge wait a cycle.
    always_comb begin
        alloc_vec  = '0;
        slot_found = 1'b0;
        for (int i = 0; i < NUM_TRACK; i++) begin
            if (!ent_valid[i] && !slot_found) begin
                alloc_vec[i] = do_alloc;
                slot_found   = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_TRACK; i++) begin : g_ent
        hazard_sb_entry u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (!bus.mem_stall),
            .alloc     (alloc_vec[i]),
            .alloc_rd  (bus.ex_rd),
            .alloc_cnt (INIT_CNT),
            .rs1       (bus.id_rs1),
            .rs2       (bus.id_rs2),
            .use_rs1   (bus.id_use_rs1),
            .use_rs2   (bus.id_use_rs2),
            .valid     (ent_valid[i]),
            .hit       (ent_hit[i])
        );
    end

    assign bus.tracker_full = full;

    // Pipeline control by priority: reset, memory freeze, branch flush, load stall.
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_bubble = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        if (!rst_n) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end else if (bus.mem_stall) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
        end else if (bus.ex_flush) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (load_haz) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic        load_stall_cyc;
    logic [31:0] perf_load_q;
    logic [31:0] perf_mem_q;

    assign load_stall_cyc = !bus.mem_stall & !bus.ex_flush & load_haz;

    // Free-running stall counters; wrap naturally, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_load_q <= '0;
            perf_mem_q  <= '0;
        end else begin
            if (load_stall_cyc) perf_load_q <= perf_load_q + 32'd1;
            if (bus.mem_stall)  perf_mem_q  <= perf_mem_q + 32'd1;
        end
    end

    assign bus.perf_load_stall = perf_load_q;
    assign bus.perf_mem_stall  = perf_mem_q;
`else
    assign bus.perf_load_stall = '0;
    assign bus.perf_mem_stall  = '0;
`endif

endmodule

// File: tb/tb_load_hazard_tracker.sv
// Bench for load_hazard_tracker: three instances (LOAD_LAT 1/3/4, two slots)
// share one stimulus stream and are compared against a queue-based model.
module tb_load_hazard_tracker;

    localparam int NT = 2;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // current stimulus
    logic [4:0] rs1, rs2, exrd;
    logic       u1, u2, isld, exv, exmr, mst, exf;

    load_hazard_tracker_if if1 ();
    load_hazard_tracker_if if3 ();
    load_hazard_tracker_if if4 ();

    load_hazard_tracker #(.LOAD_LAT(1), .NUM_TRACK(NT)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    load_hazard_tracker #(.LOAD_LAT(3), .NUM_TRACK(NT)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    load_hazard_tracker #(.LOAD_LAT(4), .NUM_TRACK(NT)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    int n_assert = 0;
    int n_fail   = 0;

    // model: each in-flight load is (rd, advancing-edge index at which it retires)
    int lat_of [3] = '{1, 3, 4};
    int q_rd   [3][$];
    int q_done [3][$];
    int act = 0;
    int e_pl [3];
    int e_pm = 0;

    bit counting = 1'b0;
    int bub_cnt [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        if1.id_rs1 = rs1; if1.id_rs2 = rs2; if1.id_use_rs1 = u1; if1.id_use_rs2 = u2; if1.id_is_load = isld;
        if1.ex_valid = exv; if1.ex_rd = exrd; if1.ex_mem_read = exmr; if1.mem_stall = mst; if1.ex_flush = exf;
        if3.id_rs1 = rs1; if3.id_rs2 = rs2; if3.id_use_rs1 = u1; if3.id_use_rs2 = u2; if3.id_is_load = isld;
        if3.ex_valid = exv; if3.ex_rd = exrd; if3.ex_mem_read = exmr; if3.mem_stall = mst; if3.ex_flush = exf;
        if4.id_rs1 = rs1; if4.id_rs2 = rs2; if4.id_use_rs1 = u1; if4.id_use_rs2 = u2; if4.id_is_load = isld;
        if4.ex_valid = exv; if4.ex_rd = exrd; if4.ex_mem_read = exmr; if4.mem_stall = mst; if4.ex_flush = exf;
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; exrd = '0;
        u1 = 0; u2 = 0; isld = 0; exv = 0; exmr = 0; mst = 0; exf = 0;
    endtask

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, tracker_full}
    function automatic logic [5:0] obs_ctl(input int k);
        case (k)
            0:       return {if1.pc_write, if1.if_id_write, if1.id_ex_bubble, if1.if_id_flush, if1.id_ex_flush, if1.tracker_full};
            1:       return {if3.pc_write, if3.if_id_write, if3.id_ex_bubble, if3.if_id_flush, if3.id_ex_flush, if3.tracker_full};
            default: return {if4.pc_write, if4.if_id_write, if4.id_ex_bubble, if4.if_id_flush, if4.id_ex_flush, if4.tracker_full};
        endcase
    endfunction

    function automatic logic [31:0] obs_pl(input int k);
        case (k)
            0:       return if1.perf_load_stall;
            1:       return if3.perf_load_stall;
            default: return if4.perf_load_stall;
        endcase
    endfunction

    function automatic logic [31:0] obs_pm(input int k);
        case (k)
            0:       return if1.perf_mem_stall;
            1:       return if3.perf_mem_stall;
            default: return if4.perf_mem_stall;
        endcase
    endfunction

    function automatic bit uses(input int r);
        return (r != 0) && ((u1 && rs1 == r) || (u2 && rs2 == r));
    endfunction

    function automatic bit ex_is_load();
        return exv && exmr && (exrd != 0);
    endfunction

    function automatic bit haz(input int k);
        bit h = ex_is_load() && uses(int'(exrd));
        foreach (q_rd[k][i]) if (uses(q_rd[k][i])) h = 1'b1;
        if (lat_of[k] > 1 && q_rd[k].size() == NT && isld) h = 1'b1;
        return h;
    endfunction

    function automatic logic [5:0] exp_ctl(input int k);
        logic f = (q_rd[k].size() == NT);
        if (!rst_n) return 6'b001000;
        if (mst)    return {5'b00000, f};
        if (exf)    return {5'b11011, f};
        if (haz(k)) return {5'b00100, f};
        return {5'b11000, f};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            q_rd[k].delete(); q_done[k].delete(); e_pl[k] = 0;
        end
        e_pm = 0;
    endtask

    task automatic model_edge();
        bit alloc [3];
        if (!rst_n) return;
        if (PERF && mst) e_pm++;
        for (int k = 0; k < 3; k++) begin
            if (PERF && !mst && !exf && haz(k)) e_pl[k]++;
            alloc[k] = (lat_of[k] > 1) && ex_is_load() && (q_rd[k].size() < NT);
        end
        if (mst) return;
        act++;
        for (int k = 0; k < 3; k++) begin
            for (int i = q_rd[k].size() - 1; i >= 0; i--)
                if (q_done[k][i] <= act) begin q_rd[k].delete(i); q_done[k].delete(i); end
            if (alloc[k]) begin q_rd[k].push_back(int'(exrd)); q_done[k].push_back(act + lat_of[k] - 1); end
        end
    endtask

    task automatic check_now(input string tag);
        logic [5:0] o;
        for (int k = 0; k < 3; k++) begin
            o = obs_ctl(k);
            chk($sformatf("%s/L%0d/ctl", tag, lat_of[k]), {26'd0, o}, {26'd0, exp_ctl(k)});
            chk($sformatf("%s/L%0d/perf_load", tag, lat_of[k]), obs_pl(k), e_pl[k]);
            chk($sformatf("%s/L%0d/perf_mem", tag, lat_of[k]), obs_pm(k), e_pm);
            if (counting && o[3]) bub_cnt[k]++;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk); apply(); #1;
        check_now(tag);
        @(posedge clk); model_edge();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); rst_n = 1'b0; model_clear(); #1;
        check_now(tag);
        idle(); apply();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); model_edge();
    endtask

    task automatic drain();
        repeat (5) begin idle(); step("drain"); end
    endtask

    task automatic dep_run(input string tag, input int rd, input bit with_ms);
        foreach (bub_cnt[k]) bub_cnt[k] = 0;
        counting = 1'b1;
        idle(); exv = 1; exmr = 1; exrd = 5'(rd); rs2 = 5'(rd); u2 = 1; step(tag);
        for (int c = 0; c < 7; c++) begin
            idle(); rs2 = 5'(rd); u2 = 1;
            mst = with_ms && (c == 1 || c == 2);
            step(tag);
        end
        counting = 1'b0;
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s/L%0d/bubble_cycles", tag, lat_of[k]), bub_cnt[k], lat_of[k]);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(); apply();
        model_clear();
        do_reset("reset");

        // single load-use: dependent on rs1 behind a load
        idle(); exv = 1; exmr = 1; exrd = 5; rs1 = 5; u1 = 1; step("ld5");
        idle(); rs1 = 5; u1 = 1; step("ld5_next");
        drain();

        // x0 never stalls, nor an unused operand
        idle(); exv = 1; exmr = 1; exrd = 0; rs1 = 0; u1 = 1; step("x0");
        idle(); exv = 1; exmr = 1; exrd = 6; rs2 = 6; u2 = 0; step("rs2_unused");
        idle(); rs2 = 6; u2 = 0; step("rs2_unused_next");
        drain();

        // stall length equals LOAD_LAT, with and without a memory freeze
        dep_run("dep7", 7, 1'b0);
        drain();
        dep_run("dep7_ms", 7, 1'b1);
        drain();

        // branch flush beats a pending load stall, scoreboard still advances
        idle(); exv = 1; exmr = 1; exrd = 8; rs1 = 8; u1 = 1; step("fl_ld");
        idle(); rs1 = 8; u1 = 1; exf = 1; step("fl_flush");
        idle(); rs1 = 8; u1 = 1; step("fl_after");
        drain();

        // fill both slots, then a load waits in ID until one frees
        idle(); exv = 1; exmr = 1; exrd = 1; step("full_a");
        idle(); exv = 1; exmr = 1; exrd = 2; step("full_b");
        idle(); isld = 1; step("full_hold");
        do_reset("reset_mid");
        idle(); isld = 1; step("post_reset");
        drain();

        // randomized traffic over a small register range to force collisions
        for (int c = 0; c < 400; c++) begin
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            exrd = 5'($urandom_range(0, 3));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            isld = ($urandom_range(0, 3) == 0);
            exv  = 1'($urandom_range(0, 1));
            exmr = 1'($urandom_range(0, 1));
            mst  = ($urandom_range(0, 7) == 0);
            exf  = ($urandom_range(0, 9) == 0);
            step("rand");
            if (c == 250) do_reset("reset_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
